// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the M-extension divide sequencer: funct3 encodings and FSM states.
package div_ctrl_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_ctrl.sv
// Sequences DIV/DIVU/REM/REMU around an external unsigned divider: sign handling,
// divide-by-zero and signed-overflow short cuts, and one-cycle writeback.
//
// state | meaning
// IDLE  | waiting for an M-extension divide/remainder op
// WAIT  | request held to the divider until its ready pulse
// DONE  | result presented on valid_o for one cycle
import div_ctrl_pkg::*;

module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              div_req_o,
    output logic [XLEN-1:0]   div_a_o,
    output logic [XLEN-1:0]   div_b_o,
    input  logic              div_ready_i,
    input  logic [2*XLEN-1:0] div_result_i,
    output logic              valid_o,
    output logic [XLEN-1:0]   result_o,
    output logic [4:0]        rd_addr_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

    state_t          state, state_n;
    logic            accept, capture, special;
    logic            is_unsigned, is_rem, div_zero, ovf;
    logic [XLEN-1:0] abs_a, abs_b, special_result, fix_result;
    logic [XLEN-1:0] quot, rem;

    logic            rem_q, unsigned_q, sign_a_q, sign_b_q;
    logic [XLEN-1:0] mag_a_q, mag_b_q, result_q;
    logic [4:0]      rd_q;

    always_comb begin
        is_unsigned = (funct3_i == F3_DIVU) || (funct3_i == F3_REMU);
        is_rem      = (funct3_i == F3_REM)  || (funct3_i == F3_REMU);
        div_zero    = (rs2_i == '0);
        ovf         = !is_unsigned && (rs1_i == MIN_NEG) && (rs2_i == '1);
        special     = div_zero || ovf;
        abs_a       = (!is_unsigned && rs1_i[XLEN-1]) ? (~rs1_i + ONE) : rs1_i;
        abs_b       = (!is_unsigned && rs2_i[XLEN-1]) ? (~rs2_i + ONE) : rs2_i;
        if (div_zero)
            special_result = is_rem ? rs1_i : '1;
        else
            special_result = is_rem ? '0 : MIN_NEG;
    end

    // Quotient sign follows the operand-sign XOR; remainder follows the dividend.
    always_comb begin
        quot = div_result_i[XLEN-1:0];
        rem  = div_result_i[2*XLEN-1:XLEN];
        if (rem_q)
            fix_result = (!unsigned_q && sign_a_q) ? (~rem + ONE) : rem;
        else
            fix_result = (!unsigned_q && (sign_a_q ^ sign_b_q)) ? (~quot + ONE) : quot;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        capture   = 1'b0;
        busy_o    = (state != ST_IDLE);
        div_req_o = (state == ST_WAIT);
        valid_o   = (state == ST_DONE) && !flush_i;
        case (state)
            ST_IDLE: begin
                if (valid_i && funct3_i[2]) begin
                    accept  = 1'b1;
                    state_n = special ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_ready_i) begin
                    capture = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (flush_i) begin
            state_n = ST_IDLE;
            accept  = 1'b0;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rem_q      <= 1'b0;
            unsigned_q <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            result_q   <= '0;
            rd_q       <= '0;
        end else if (accept) begin
            rem_q      <= is_rem;
            unsigned_q <= is_unsigned;
            sign_a_q   <= !is_unsigned && rs1_i[XLEN-1];
            sign_b_q   <= !is_unsigned && rs2_i[XLEN-1];
            mag_a_q    <= abs_a;
            mag_b_q    <= abs_b;
            rd_q       <= rd_addr_i;
            if (special)
                result_q <= special_result;
        end else if (capture) begin
            result_q <= fix_result;
        end
    end

    assign div_a_o   = mag_a_q;
    assign div_b_o   = mag_b_q;
    assign result_o  = result_q;
    assign rd_addr_o = rd_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a fixed-latency unsigned divider model.
module tb_div_ctrl;

    localparam int LAT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        div_req_o;
    logic [31:0] div_a_o, div_b_o;
    logic        div_ready_i = 1'b0;
    logic [63:0] div_result_i = '0;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int failures = 0;

    div_ctrl #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct3_i(funct3_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .busy_o(busy_o), .div_req_o(div_req_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .valid_o(valid_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Divider model: latches operands when the request is first seen and pulses
    // ready so the controller samples it on the LAT-th rising edge of the request.
    logic        dv_run = 1'b0;
    int          dv_cnt = 0;
    int          req_starts = 0;
    logic [31:0] last_a = '0, last_b = '0;

    always @(negedge clk_i) begin
        if (div_ready_i) begin
            div_ready_i = 1'b0;
            dv_run = 1'b0;
        end else if (dv_run) begin
            if (dv_cnt == 1) begin
                div_ready_i = 1'b1;
                div_result_i = {last_a % last_b, last_a / last_b};
            end else begin
                dv_cnt = dv_cnt - 1;
            end
        end else if (div_req_o) begin
            dv_run = 1'b1;
            dv_cnt = LAT - 1;
            last_a = div_a_o;
            last_b = div_b_o;
            req_starts = req_starts + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res,
                          output logic [4:0] tg, output int lat, output int reqs);
        int r0;
        r0 = req_starts;
        res = '0;
        tg = '0;
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_addr_i = tag;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = n;
                res = result_o;
                tg = rd_addr_o;
                break;
            end
        end
        reqs = req_starts - r0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, exp_res;
        int          exp_lat, exp_req;
        logic [31:0] exp_da, exp_db;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] res;
        logic [4:0]  tg;
        int          lat, reqs, r0;
        logic        seen;

        vecs[0]  = '{3'b100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 5, 1, 32'h7, 32'h2};
        vecs[1]  = '{3'b110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 5, 1, 32'h7, 32'h2};
        vecs[2]  = '{3'b111, 32'hFFFFFFF9, 32'h2, 32'h00000001, 5, 1, 32'hFFFFFFF9, 32'h2};
        vecs[3]  = '{3'b101, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC, 5, 1, 32'hFFFFFFF9, 32'h2};
        vecs[4]  = '{3'b100, 32'h5, 32'h0, 32'hFFFFFFFF, 1, 0, 32'h0, 32'h0};
        vecs[5]  = '{3'b110, 32'h5, 32'h0, 32'h00000005, 1, 0, 32'h0, 32'h0};
        vecs[6]  = '{3'b101, 32'h5, 32'h0, 32'hFFFFFFFF, 1, 0, 32'h0, 32'h0};
        vecs[7]  = '{3'b111, 32'h5, 32'h0, 32'h00000005, 1, 0, 32'h0, 32'h0};
        vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 32'h0, 32'h0};
        vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h0, 32'h0};
        vecs[10] = '{3'b100, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 5, 1, 32'h7, 32'h2};
        vecs[11] = '{3'b100, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'h00000004, 5, 1, 32'h8, 32'h2};
        vecs[12] = '{3'b110, 32'h7, 32'hFFFFFFFD, 32'h00000001, 5, 1, 32'h7, 32'h3};
        vecs[13] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 5, 1, 32'h80000000, 32'hFFFFFFFF};
        vecs[14] = '{3'b100, 32'h80000000, 32'h2, 32'hC0000000, 5, 1, 32'h80000000, 32'h2};

        #2;
        check("reset_busy", {31'b0, busy_o}, 32'h0);
        check("reset_valid", {31'b0, valid_o}, 32'h0);
        check("reset_req", {31'b0, div_req_o}, 32'h0);
        check("reset_result", result_o, 32'h0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), res, tg, lat, reqs);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_rd", i), {27'b0, tg}, 32'(i + 1));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_req_count", i), 32'(reqs), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req == 1) begin
                check($sformatf("v%0d_div_a", i), last_a, vecs[i].exp_da);
                check($sformatf("v%0d_div_b", i), last_b, vecs[i].exp_db);
            end
            @(negedge clk_i);
            check($sformatf("v%0d_valid_pulse", i), {31'b0, valid_o}, 32'h0);
            check($sformatf("v%0d_idle_after", i), {31'b0, busy_o}, 32'h0);
            repeat (2) @(negedge clk_i);
        end

        // Non-divide funct3 must be ignored.
        r0 = req_starts;
        valid_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'h9; rs2_i = 32'h3;
        @(negedge clk_i);
        valid_i = 1'b0;
        check("non_m_busy", {31'b0, busy_o}, 32'h0);
        @(negedge clk_i);
        check("non_m_valid", {31'b0, valid_o}, 32'h0);
        check("non_m_req", 32'(req_starts - r0), 32'h0);

        // New op offered while busy is dropped.
        valid_i = 1'b1; funct3_i = 3'b100; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd9;
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'b110; rs1_i = 32'd1; rs2_i = 32'd0; rd_addr_i = 5'd3;
        check("busy_during_wait", {31'b0, busy_o}, 32'h1);
        @(negedge clk_i);
        valid_i = 1'b0;
        lat = 99;
        for (int n = 2; n <= 20; n++) begin
            if (valid_o) begin lat = n; break; end
            @(negedge clk_i);
        end
        check("busy_ign_latency", 32'(lat), 32'd5);
        check("busy_ign_result", result_o, 32'd14);
        check("busy_ign_rd", {27'b0, rd_addr_o}, 32'd9);
        seen = 1'b0;
        repeat (4) begin @(negedge clk_i); if (valid_o) seen = 1'b1; end
        check("busy_ign_no_extra", {31'b0, seen}, 32'h0);

        // Flush in the second WAIT cycle; the late ready pulse must not complete anything.
        @(negedge clk_i);
        valid_i = 1'b1; funct3_i = 3'b100; rs1_i = 32'd20; rs2_i = 32'd3; rd_addr_i = 5'd4;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("flush_pre_req", {31'b0, div_req_o}, 32'h1);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("flush_busy", {31'b0, busy_o}, 32'h0);
        check("flush_req", {31'b0, div_req_o}, 32'h0);
        flush_i = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk_i); if (valid_o) seen = 1'b1; end
        check("flush_no_valid", {31'b0, seen}, 32'h0);
        run_op(3'b100, 32'd100, 32'hFFFFFFF9, 5'd21, res, tg, lat, reqs);
        check("post_flush_result", res, 32'hFFFFFFF2);
        check("post_flush_rd", {27'b0, tg}, 32'd21);
        check("post_flush_latency", 32'(lat), 32'd5);
        repeat (3) @(negedge clk_i);

        // Reset asserted mid-WAIT.
        valid_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd50; rs2_i = 32'd6; rd_addr_i = 5'd17;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_pre_a", div_a_o, 32'd50);
        rst_i = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        check("rst_req", {31'b0, div_req_o}, 32'h0);
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_result", result_o, 32'h0);
        check("rst_rd", {27'b0, rd_addr_o}, 32'h0);
        check("rst_a", div_a_o, 32'h0);
        check("rst_b", div_b_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        seen = 1'b0;
        repeat (8) begin @(negedge clk_i); if (valid_o) seen = 1'b1; end
        check("rst_no_valid", {31'b0, seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
